instruction_fetch: RTL and testbench

- Sits directly downstream of `program_counter`: consumes its `out` value and drives its `pc_enable` and `ld` inputs.
- Reads instruction bytes from program memory over a ready handshake and latches each opcode into an instruction register.
- Resolves absolute jumps internally (two-byte instruction) and handles halt.
- Presents every other opcode to the decode stage with a valid/ready handshake.

---
 rtl/instruction_fetch_if.sv | 27 ++
 rtl/instruction_fetch.sv | 114 +++++++++++
 tb/tb_instruction_fetch.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - fetch-stage bundle: PC control, program memory read, IR handshake
interface instruction_fetch_if;
    logic       run;
    logic [7:0] pc_in;
    logic       pc_enable;
    logic       ld;
    logic [7:0] pc_load_val;
    logic       mem_rd;
    logic [7:0] mem_addr;
    logic       mem_ready;
    logic [7:0] mem_data;
    logic [7:0] ir_out;
    logic       ir_valid;
    logic       ir_ready;
    logic       halted;
    logic       fetch_err;

    modport master (
        input  run, pc_in, mem_ready, mem_data, ir_ready,
        output pc_enable, ld, pc_load_val, mem_rd, mem_addr, ir_out, ir_valid, halted, fetch_err
    );

    modport slave (
        output run, pc_in, mem_ready, mem_data, ir_ready,
        input  pc_enable, ld, pc_load_val, mem_rd, mem_addr, ir_out, ir_valid, halted, fetch_err
    );
endinterface

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - byte fetch into IR, internal absolute JMP, HLT, IR valid/ready to decode
// Optional FETCH_TIMEOUT_EN: bounded memory wait; expiry sets sticky fetch_err and halts.
module instruction_fetch #(
    parameter logic [3:0]  JMP_OPC = 4'hC,
    parameter logic [3:0]  HLT_OPC = 4'hF,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    instruction_fetch_if.master bus
);
    typedef enum logic [2:0] {IDLE, FETCH, TARGET, HOLD, HALT} state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] ir;
    logic       timeout_hit;

`ifdef FETCH_TIMEOUT_EN
    logic [3:0] wait_cnt;
    logic       err;
    logic       waiting;

    // Every exit from FETCH/TARGET happens on mem_ready, so clearing on ready also covers state entry.
    assign waiting     = ((state == FETCH) || (state == TARGET)) && !bus.mem_ready;
    assign timeout_hit = waiting && (wait_cnt == 4'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= 4'd0;
            err      <= 1'b0;
        end else begin
            wait_cnt <= waiting ? wait_cnt + 4'd1 : 4'd0;
            if (timeout_hit) begin
                err <= 1'b1;
            end
        end
    end

    assign bus.fetch_err = err;
`else
    assign timeout_hit   = 1'b0;
    assign bus.fetch_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ir    <= 8'h00;
        end else begin
            state <= state_next;
            if ((state == FETCH) && bus.mem_ready) begin
                ir <= bus.mem_data;
            end
        end
    end

    always_comb begin
        state_next      = state;
        bus.mem_rd      = 1'b0;
        bus.pc_enable   = 1'b0;
        bus.ld          = 1'b0;
        bus.pc_load_val = 8'h00;
        case (state)
            IDLE: begin
                if (bus.run) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                bus.mem_rd = 1'b1;
                if (bus.mem_ready) begin
                    bus.pc_enable = 1'b1;
                    if (bus.mem_data[7:4] == JMP_OPC) begin
                        state_next = TARGET;
                    end else if (bus.mem_data[7:4] == HLT_OPC) begin
                        state_next = HALT;
                    end else begin
                        state_next = HOLD;
                    end
                end else if (timeout_hit) begin
                    state_next = HALT;
                end
            end
            TARGET: begin
                // The target byte replaces the PC, so no increment accompanies the load.
                bus.mem_rd = 1'b1;
                if (bus.mem_ready) begin
                    bus.ld          = 1'b1;
                    bus.pc_load_val = bus.mem_data;
                    state_next      = bus.run ? FETCH : IDLE;
                end else if (timeout_hit) begin
                    state_next = HALT;
                end
            end
            HOLD: begin
                if (bus.ir_ready) begin
                    state_next = bus.run ? FETCH : IDLE;
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.mem_addr = bus.pc_in;
    assign bus.ir_out   = ir;
    assign bus.ir_valid = (state == HOLD);
    assign bus.halted   = (state == HALT);
endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - scoreboard bench: ISA-level model predicts reads, jump loads and delivered opcodes
module tb_instruction_fetch;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    instruction_fetch_if bus();

    instruction_fetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] mem [256];
    logic [7:0] pc = 8'h00;
    logic       run_d = 1'b0, run_r = 1'b0;
    logic       rdy_d = 1'b1, rdy_r = 1'b1;
    logic       rand_mode = 1'b0;
    logic       mem_ready_r = 1'b0;
    logic       req_active = 1'b0;
    int         wait_left = 0;
    int         max_wait = 0;
    logic       stall_en = 1'b0;
    logic [7:0] stall_addr = 8'h00;
    logic       mon_en = 1'b1;
    logic       err_chk = 1'b1;

    int checks = 0;
    int passes = 0;

    logic [7:0] exp_addr[$];
    logic [7:0] exp_tgt[$];
    logic [7:0] exp_ir[$];

    assign bus.run       = rand_mode ? run_r : run_d;
    assign bus.ir_ready  = rand_mode ? rdy_r : rdy_d;
    assign bus.pc_in     = pc;
    assign bus.mem_ready = mem_ready_r;
    assign bus.mem_data  = mem[bus.mem_addr];

    // Program counter as seen by the fetch stage
    always @(posedge clk or posedge reset) begin
        if (reset)              pc <= 8'h00;
        else if (bus.ld)        pc <= bus.pc_load_val;
        else if (bus.pc_enable) pc <= pc + 8'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Memory with random wait states, plus random run / ir_ready in random mode
    always @(negedge clk) begin
        if (reset) begin
            mem_ready_r = 1'b0;
            req_active  = 1'b0;
        end else begin
            if (mem_ready_r) req_active = 1'b0;
            if (bus.mem_rd) begin
                if (!req_active) begin
                    req_active = 1'b1;
                    wait_left  = (max_wait == 0) ? 0 : int'($urandom_range(0, max_wait));
                end
                if (stall_en && bus.mem_addr == stall_addr) begin
                    mem_ready_r = 1'b0;
                end else if (wait_left == 0) begin
                    mem_ready_r = 1'b1;
                end else begin
                    mem_ready_r = 1'b0;
                    wait_left--;
                end
            end else begin
                mem_ready_r = 1'b0;
            end
        end
        run_r = ($urandom_range(0, 3) != 0);
        rdy_r = $urandom_range(0, 1) == 1;
    end

    // Monitor: pops expectations whenever the DUT completes a read, a load or a delivery
    always @(negedge clk) begin
        #3;
        if (!reset && mon_en) begin
            if (bus.mem_rd && bus.mem_ready) begin
                check("read_expected", 32'(exp_addr.size() != 0), 32'd1);
                if (exp_addr.size() != 0) check("read_addr", 32'(bus.mem_addr), 32'(exp_addr.pop_front()));
            end
            if (bus.ld) begin
                check("ld_expected", 32'(exp_tgt.size() != 0), 32'd1);
                if (exp_tgt.size() != 0) check("ld_target", 32'(bus.pc_load_val), 32'(exp_tgt.pop_front()));
            end
            if (bus.ir_valid && bus.ir_ready) begin
                check("ir_expected", 32'(exp_ir.size() != 0), 32'd1);
                if (exp_ir.size() != 0) check("ir_out", 32'(bus.ir_out), 32'(exp_ir.pop_front()));
            end
            check("pc_en_ld_exclusive", 32'(bus.pc_enable & bus.ld), 32'd0);
            if (!bus.ld) check("pc_load_val_idle", 32'(bus.pc_load_val), 32'd0);
            if (bus.mem_rd) check("mem_addr_is_pc", 32'(bus.mem_addr), 32'(pc));
            if (err_chk) check("fetch_err_clear", 32'(bus.fetch_err), 32'd0);
        end
    end

    // Instruction-level model: walk the program from address 0 until HLT
    task automatic model_run(output bit ok);
        logic [7:0] p;
        logic [7:0] op;
        p  = 8'h00;
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            op = mem[p];
            exp_addr.push_back(p);
            p = p + 8'd1;
            if (op[7:4] == 4'hC) begin
                exp_addr.push_back(p);
                exp_tgt.push_back(mem[p]);
                p = mem[p];
            end else if (op[7:4] == 4'hF) begin
                ok = 1'b1;
                return;
            end else begin
                exp_ir.push_back(op);
            end
        end
    endtask

    task automatic clear_queues();
        exp_addr.delete();
        exp_tgt.delete();
        exp_ir.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_reads_left"}, 32'(exp_addr.size()), 32'd0);
        check({tag, "_loads_left"}, 32'(exp_tgt.size()), 32'd0);
        check({tag, "_irs_left"}, 32'(exp_ir.size()), 32'd0);
    endtask

    initial begin
        bit ok;
        int n;
        logic [7:0] b;

        foreach (mem[i]) mem[i] = 8'h00;
        mem[8'h00] = 8'h12;
        mem[8'h01] = 8'hC0;
        mem[8'h02] = 8'h18;
        mem[8'h18] = 8'h34;
        mem[8'h19] = 8'hF0;

        tick();
        check("rst_ir_out", 32'(bus.ir_out), 32'h00);
        check("rst_ir_valid", 32'(bus.ir_valid), 32'd0);
        check("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
        check("rst_pc_enable", 32'(bus.pc_enable), 32'd0);
        check("rst_ld", 32'(bus.ld), 32'd0);
        check("rst_halted", 32'(bus.halted), 32'd0);
        check("rst_fetch_err", 32'(bus.fetch_err), 32'd0);
        check("rst_pc_load_val", 32'(bus.pc_load_val), 32'h00);

        // Directed program with zero-wait memory
        clear_queues();
        model_run(ok);
        do_reset();
        run_d = 1'b1;
        tick();
        check("d_fetch0_rd", 32'(bus.mem_rd), 32'd1);
        check("d_fetch0_addr", 32'(bus.mem_addr), 32'h00);
        check("d_fetch0_pcen", 32'(bus.pc_enable), 32'd1);
        tick();
        check("d_hold_valid", 32'(bus.ir_valid), 32'd1);
        check("d_hold_ir", 32'(bus.ir_out), 32'h12);
        check("d_hold_pc", 32'(pc), 32'h01);
        tick();
        check("d_jmp_pcen", 32'(bus.pc_enable), 32'd1);
        check("d_jmp_addr", 32'(bus.mem_addr), 32'h01);
        tick();
        check("d_tgt_ld", 32'(bus.ld), 32'd1);
        check("d_tgt_val", 32'(bus.pc_load_val), 32'h18);
        check("d_tgt_pcen", 32'(bus.pc_enable), 32'd0);
        check("d_tgt_addr", 32'(bus.mem_addr), 32'h02);
        check("d_tgt_novalid", 32'(bus.ir_valid), 32'd0);
        rdy_d = 1'b0;
        tick();
        check("d_after_jmp_addr", 32'(bus.mem_addr), 32'h18);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("d_stall_valid", 32'(bus.ir_valid), 32'd1);
            check("d_stall_ir", 32'(bus.ir_out), 32'h34);
            check("d_stall_no_rd", 32'(bus.mem_rd), 32'd0);
            check("d_stall_pc", 32'(pc), 32'h19);
            if (i < 3) tick();
        end
        rdy_d = 1'b1;
        tick();
        check("d_hlt_addr", 32'(bus.mem_addr), 32'h19);
        tick();
        for (int i = 0; i < 20; i++) begin
            run_d = i[0];
            check("d_halted", 32'(bus.halted), 32'd1);
            check("d_halt_no_rd", 32'(bus.mem_rd), 32'd0);
            tick();
        end
        check_drained("d");
        reset = 1'b1;
        #1;
        check("d_reset_halted", 32'(bus.halted), 32'd0);
        tick();
        reset = 1'b0;
        run_d = 1'b0;

        // Random programs with random waits, run and ir_ready
        for (int p = 0; p < 6; p++) begin
            clear_queues();
            ok = 1'b0;
            while (!ok) begin
                clear_queues();
                foreach (mem[i]) begin
                    b = 8'($urandom);
                    n = int'($urandom_range(0, 15));
                    if (n < 2) b[7:4] = 4'hF;
                    else if (n < 4) b[7:4] = 4'hC;
                    else b[7:4] = 4'($urandom_range(0, 11));
                    mem[i] = b;
                end
                model_run(ok);
            end
            max_wait = (p == 0) ? 0 : 4;
            do_reset();
            rand_mode = 1'b1;
            n = 0;
            while (!bus.halted && n < 8000) begin
                tick();
                n++;
            end
            check("r_halted_reached", 32'(bus.halted), 32'd1);
            for (int i = 0; i < 20; i++) begin
                tick();
                check("r_halt_no_rd", 32'(bus.mem_rd), 32'd0);
            end
            rand_mode = 1'b0;
            check_drained("r");
        end

        // Reset while TARGET waits on memory: no load may escape
        clear_queues();
        max_wait = 0;
        mem[8'h00] = 8'hC0;
        mem[8'h01] = 8'h18;
        exp_addr.push_back(8'h00);
        stall_en = 1'b1;
        stall_addr = 8'h01;
        rdy_d = 1'b1;
        do_reset();
        run_d = 1'b1;
        tick();
        tick();
        tick();
        tick();
        check("t_wait_rd", 32'(bus.mem_rd), 32'd1);
        check("t_wait_addr", 32'(bus.mem_addr), 32'h01);
        check("t_wait_ld", 32'(bus.ld), 32'd0);
        #1;
        reset = 1'b1;
        #1;
        check("t_rst_rd", 32'(bus.mem_rd), 32'd0);
        check("t_rst_ld", 32'(bus.ld), 32'd0);
        check("t_rst_pcen", 32'(bus.pc_enable), 32'd0);
        check("t_rst_val", 32'(bus.pc_load_val), 32'h00);
        check("t_rst_addr", 32'(bus.mem_addr), 32'(pc));
        tick();
        reset = 1'b0;
        run_d = 1'b0;
        stall_en = 1'b0;
        tick();
        check_drained("t");

`ifdef FETCH_TIMEOUT_EN
        // Memory never answers: halt with fetch_err after the wait limit
        clear_queues();
        stall_en = 1'b1;
        stall_addr = 8'h00;
        err_chk = 1'b0;
        do_reset();
        run_d = 1'b1;
        n = 0;
        while (!bus.halted && n < 40) begin
            tick();
            n++;
        end
        check("to_cycles", 32'(n), 32'd16);
        check("to_fetch_err", 32'(bus.fetch_err), 32'd1);
        check("to_halted", 32'(bus.halted), 32'd1);
        reset = 1'b1;
        #1;
        check("to_err_cleared", 32'(bus.fetch_err), 32'd0);
        tick();
        reset = 1'b0;
        stall_en = 1'b0;
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
